vram_sync_copier: RTL and testbench

- Parametrised successor to the single-region producer-to-consumer VRAM sync writer.
- On a `sync` pulse, mirror-copies up to NUM_REGIONS selectable address regions from the source (CPU-side) VRAM copy to the destination (PPU-side) copy.
- Copies are fully pipelined: one word per cycle, no bubbles between regions.
- Sits between the two VRAM buffers; the frame controller drives `sync` at vblank.

---
 rtl/vram_sync_pkg.sv | 44 ++++
 rtl/vram_sync_copier_if.sv | 36 +++
 rtl/vram_copy_pipe.sv | 44 ++++
 rtl/vram_sync_copier.sv | 185 ++++++++++++++++++
 tb/tb_vram_sync_copier.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_sync_pkg.sv
// Shared types and helpers for the VRAM sync copier.
// Holds FSM states, the region record and the packed-port unpacker.
package vram_sync_pkg;

    localparam int DEF_DATA_W      = 64;
    localparam int DEF_ADDR_W      = 12;
    localparam int DEF_NUM_REGIONS = 4;
    localparam int DEF_RD_LAT      = 2;
    localparam int BUS_W           = 1024;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        DRAIN,
        DONE
    } copy_state_e;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] len;
    } region_t;

    // Pull region idx out of the packed base/len ports.
    function automatic region_t unpack_region(
        input logic [BUS_W-1:0] base_bus,
        input logic [BUS_W-1:0] len_bus,
        input int               idx,
        input int               aw
    );
        logic [BUS_W-1:0] b;
        logic [BUS_W-1:0] l;
        logic [31:0]      am;
        logic [31:0]      lm;
        region_t          r;
        b      = base_bus >> (idx * aw);
        l      = len_bus >> (idx * (aw + 1));
        am     = (32'd1 << aw) - 32'd1;
        lm     = (32'd1 << (aw + 1)) - 32'd1;
        r.base = 32'(b) & am;
        r.len  = 32'(l) & lm;
        return r;
    endfunction

endpackage

// File: rtl/vram_sync_copier_if.sv
// Bus bundle between the frame side, the two VRAM copies and the copier.
// master drives requests and source data; slave is the copier.
interface vram_sync_copier_if
    import vram_sync_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int NUM_REGIONS = DEF_NUM_REGIONS
);
    logic                            sync;
    logic [NUM_REGIONS-1:0]          sync_mask;
    logic [NUM_REGIONS*ADDR_W-1:0]   region_base;
    logic [NUM_REGIONS*(ADDR_W+1)-1:0] region_len;
    logic                            busy;
    logic                            done;
    logic                            overrun;
    logic                            src_rd_en;
    logic [ADDR_W-1:0]               src_addr;
    logic [DATA_W-1:0]               src_rdata;
    logic                            dst_wr_en;
    logic [ADDR_W-1:0]               dst_addr;
    logic [DATA_W-1:0]               dst_wdata;

    modport master (
        output sync, sync_mask, region_base, region_len, src_rdata,
        input  busy, done, overrun, src_rd_en, src_addr,
        input  dst_wr_en, dst_addr, dst_wdata
    );

    modport slave (
        input  sync, sync_mask, region_base, region_len, src_rdata,
        output busy, done, overrun, src_rd_en, src_addr,
        output dst_wr_en, dst_addr, dst_wdata
    );

endinterface

// File: rtl/vram_copy_pipe.sv
// Read-latency delay line carrying {valid, addr} alongside source reads.
// Its tail lines up with src_rdata to form the destination write.
module vram_copy_pipe #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              vld_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              empty_next_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [ADDR_W-1:0] addr_q [RD_LAT];

    // Shift issued reads toward the write port; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
        end else begin
            vld_q[0]  <= vld_i;
            addr_q[0] <= addr_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign vld_o  = vld_q[RD_LAT-1];
    assign addr_o = addr_q[RD_LAT-1];

    // Only the tail may still hold a read: pipe is empty after this cycle.
    always_comb begin
        empty_next_o = 1'b1;
        for (int i = 0; i < RD_LAT - 1; i++)
            if (vld_q[i]) empty_next_o = 1'b0;
    end

endmodule

// File: rtl/vram_sync_copier.sv
// Copies up to NUM_REGIONS VRAM regions from source to destination on sync.
// One read per cycle across regions; writes trail reads by RD_LAT cycles.
module vram_sync_copier
    import vram_sync_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int RD_LAT      = DEF_RD_LAT
) (
    input logic               clk,
    input logic               rst,
    vram_sync_copier_if.slave bus
);

    localparam int IW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam logic [ADDR_W:0]   ONE_C = 1;
    localparam logic [ADDR_W-1:0] INC_A = 1;

    copy_state_e            state_q, state_d;
    logic [BUS_W-1:0]       base_bus, len_bus;
    region_t                r_in [NUM_REGIONS];
    logic [ADDR_W-1:0]      in_base [NUM_REGIONS];
    logic [ADDR_W:0]        in_len [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] in_nz;
    logic [ADDR_W-1:0]      base_q [NUM_REGIONS];
    logic [ADDR_W:0]        len_q [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] mask_q, mask_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W:0]        cnt_q, cnt_d;
    logic                   rd_en_q, rd_en_d;
    logic                   pend_q, pend_d;
    logic                   ovr_q, ovr_d;
    logic                   accept;
    logic [IW-1:0]          j_in, j_rem;
    logic                   pipe_vld;
    logic [ADDR_W-1:0]      pipe_addr;
    logic                   pipe_empty_next;

    function automatic logic [IW-1:0] first_set(
        input logic [NUM_REGIONS-1:0] m
    );
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--)
            if (m[i]) idx = IW'(i);
        return idx;
    endfunction

    // Unpack the live region table; zero-length regions never get a slot.
    always_comb begin
        base_bus = '0;
        len_bus  = '0;
        base_bus[NUM_REGIONS*ADDR_W-1:0]     = bus.region_base;
        len_bus[NUM_REGIONS*(ADDR_W+1)-1:0]  = bus.region_len;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            r_in[i]    = unpack_region(base_bus, len_bus, i, ADDR_W);
            in_base[i] = ADDR_W'(r_in[i].base);
            in_len[i]  = (ADDR_W+1)'(r_in[i].len);
            in_nz[i]   = bus.sync_mask[i] && (r_in[i].len != 32'd0);
        end
    end

    // FSM state and read-issue registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rd_en_q <= rd_en_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    // Latch the region table when a request is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                base_q[i] <= in_base[i];
                len_q[i]  <= in_len[i];
            end
        end
    end

    // Next state, region walk, pending/overrun and request acceptance.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rd_en_d = rd_en_q;
        pend_d  = pend_q;
        ovr_d   = 1'b0;
        accept  = 1'b0;
        j_in    = first_set(in_nz);
        j_rem   = first_set(mask_q);

        if (bus.sync && (state_q == COPY || state_q == DRAIN)) begin
            if (pend_q) ovr_d  = 1'b1;
            else        pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: accept = bus.sync;
            COPY: begin
                if (cnt_q > ONE_C) begin
                    addr_d = addr_q + INC_A;
                    cnt_d  = cnt_q - ONE_C;
                end else if (|mask_q) begin
                    addr_d = base_q[j_rem];
                    cnt_d  = len_q[j_rem];
                    mask_d = mask_q & ~(NUM_REGIONS'(1) << j_rem);
                end else begin
                    rd_en_d = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN: if (pipe_empty_next) state_d = DONE;
            DONE: begin
                if (pend_q) begin
                    accept = 1'b1;
                    pend_d = 1'b0;
                    ovr_d  = bus.sync;
                end else if (bus.sync) begin
                    accept = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (|in_nz) begin
                addr_d  = in_base[j_in];
                cnt_d   = in_len[j_in];
                mask_d  = in_nz & ~(NUM_REGIONS'(1) << j_in);
                rd_en_d = 1'b1;
                state_d = COPY;
            end else begin
                mask_d  = '0;
                rd_en_d = 1'b0;
                state_d = DONE;
            end
        end
    end

    vram_copy_pipe #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_pipe (
        .clk          (clk),
        .rst          (rst),
        .vld_i        (rd_en_q),
        .addr_i       (addr_q),
        .vld_o        (pipe_vld),
        .addr_o       (pipe_addr),
        .empty_next_o (pipe_empty_next)
    );

    assign bus.busy      = (state_q == COPY) || (state_q == DRAIN);
    assign bus.done      = (state_q == DONE);
    assign bus.overrun   = ovr_q;
    assign bus.src_rd_en = rd_en_q;
    assign bus.src_addr  = addr_q;
    assign bus.dst_wr_en = pipe_vld;
    assign bus.dst_addr  = pipe_addr;
    assign bus.dst_wdata = pipe_vld ? bus.src_rdata : '0;

endmodule

// File: tb/tb_vram_sync_copier.sv
// Bench for vram_sync_copier: directed scenarios plus randomized tables,
// checked against a cycle-level reference of the copy schedule.
module tb_vram_sync_copier;

    localparam int DW = 64;
    localparam int AW = 12;
    localparam int NR = 4;
    localparam int RL = 2;

    typedef struct packed {
        int          cyc;
        logic [11:0] addr;
        logic [63:0] data;
    } ev_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;

    vram_sync_copier_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGIONS(NR)) ifc ();

    vram_sync_copier #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_REGIONS(NR), .RD_LAT(RL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    logic [11:0] tb_base [NR];
    logic [12:0] tb_len [NR];
    logic [3:0]  tb_mask;
    logic [63:0] rdp [RL];
    logic [63:0] dst_mem [4096];

    ev_t obs_rd[$], obs_wr[$], exp_rd[$], exp_wr[$];
    int  obs_done[$], exp_done[$], obs_ovr[$], exp_ovr[$];
    int  obs_busy_n, obs_busy_first, obs_busy_last;
    int  exp_busy_n, exp_busy_first, exp_busy_last;
    int  last_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Source VRAM: mem[a] = a, returned RL cycles after the read strobe.
    always @(posedge clk) begin
        rdp[0] <= ifc.src_rd_en ? {52'h0, ifc.src_addr} : 64'hBADD_BADD_BADD_BADD;
        for (int i = 1; i < RL; i++) rdp[i] <= rdp[i-1];
    end
    assign ifc.src_rdata = rdp[RL-1];

    always @(negedge clk) begin
        if (ifc.src_rd_en) obs_rd.push_back(ev_t'{cyc, ifc.src_addr, 64'h0});
        if (ifc.dst_wr_en) begin
            obs_wr.push_back(ev_t'{cyc, ifc.dst_addr, ifc.dst_wdata});
            dst_mem[ifc.dst_addr] = ifc.dst_wdata;
        end
        if (ifc.done) obs_done.push_back(cyc);
        if (ifc.overrun) obs_ovr.push_back(cyc);
        if (ifc.busy) begin
            obs_busy_n++;
            if (obs_busy_first < 0) obs_busy_first = cyc;
            obs_busy_last = cyc;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int c);
        goto(c);
        ifc.sync = 1'b1;
        @(posedge clk);
        #1;
        ifc.sync = 1'b0;
    endtask

    task automatic drive_tables();
        for (int i = 0; i < NR; i++) begin
            ifc.region_base[i*12 +: 12] = tb_base[i];
            ifc.region_len[i*13 +: 13]  = tb_len[i];
        end
        ifc.sync_mask = tb_mask;
    endtask

    task automatic set_tables(input logic [3:0] m);
        tb_mask = m;
        drive_tables();
    endtask

    task automatic clear_logs();
        obs_rd.delete(); obs_wr.delete(); exp_rd.delete(); exp_wr.delete();
        obs_done.delete(); exp_done.delete(); obs_ovr.delete(); exp_ovr.delete();
        obs_busy_n = 0; obs_busy_first = -1; obs_busy_last = -1;
        exp_busy_n = 0; exp_busy_first = -1; exp_busy_last = -1;
    endtask

    // Reference: walk enabled regions in index order, one word per cycle.
    task automatic model_add(input int a, output int d);
        int s;
        logic [11:0] ad;
        s = 0;
        for (int i = 0; i < NR; i++) begin
            if (tb_mask[i]) begin
                for (int k = 0; k < int'(tb_len[i]); k++) begin
                    ad = 12'((int'(tb_base[i]) + k) % 4096);
                    exp_rd.push_back(ev_t'{a + 1 + s, ad, 64'h0});
                    exp_wr.push_back(ev_t'{a + 1 + s + RL, ad, {52'h0, ad}});
                    s++;
                end
            end
        end
        d = (s == 0) ? a + 1 : a + s + RL + 1;
        exp_done.push_back(d);
        if (s > 0) begin
            exp_busy_n += d - a - 1;
            if (exp_busy_first < 0) exp_busy_first = a + 1;
            exp_busy_last = d - 1;
        end
        last_s = s;
    endtask

    function automatic int first_done();
        return (obs_done.size() > 0) ? obs_done[0] : -1;
    endfunction

    task automatic compare_logs(input string t);
        int bad;
        chk({t, " rd count"}, obs_rd.size(), exp_rd.size());
        bad = 0;
        foreach (exp_rd[i])
            if (i >= obs_rd.size() || obs_rd[i] !== exp_rd[i]) bad++;
        chk({t, " rd sequence"}, bad, 0);
        chk({t, " wr count"}, obs_wr.size(), exp_wr.size());
        bad = 0;
        foreach (exp_wr[i])
            if (i >= obs_wr.size() || obs_wr[i] !== exp_wr[i]) bad++;
        chk({t, " wr sequence"}, bad, 0);
        chk({t, " done count"}, obs_done.size(), exp_done.size());
        bad = 0;
        foreach (exp_done[i])
            if (i >= obs_done.size() || obs_done[i] !== exp_done[i]) bad++;
        chk({t, " done cycles"}, bad, 0);
        chk({t, " overrun count"}, obs_ovr.size(), exp_ovr.size());
        bad = 0;
        foreach (exp_ovr[i])
            if (i >= obs_ovr.size() || obs_ovr[i] !== exp_ovr[i]) bad++;
        chk({t, " overrun cycles"}, bad, 0);
        chk({t, " busy cycles"}, obs_busy_n, exp_busy_n);
        chk({t, " busy first"}, obs_busy_first, exp_busy_first);
        chk({t, " busy last"}, obs_busy_last, exp_busy_last);
    endtask

    initial begin
        int a, d1, d2, bad;
        cyc = 0; n_vec = 0; n_err = 0;
        rst = 1'b1;
        ifc.sync = 1'b0;
        for (int i = 0; i < NR; i++) begin
            tb_base[i] = '0;
            tb_len[i]  = '0;
        end
        set_tables(4'b0000);
        for (int i = 0; i < 4096; i++) dst_mem[i] = 64'hDEAD_BEEF_DEAD_BEEF;
        clear_logs();

        // Reset state
        goto(3);
        @(negedge clk);
        chk("reset busy", ifc.busy, 0);
        chk("reset done", ifc.done, 0);
        chk("reset overrun", ifc.overrun, 0);
        chk("reset src_rd_en", ifc.src_rd_en, 0);
        chk("reset dst_wr_en", ifc.dst_wr_en, 0);
        chk("reset src_addr", ifc.src_addr, 0);
        chk("reset dst_addr", ifc.dst_addr, 0);
        chk("reset dst_wdata", ifc.dst_wdata, 0);
        goto(4);
        rst = 1'b0;
        goto(8);

        // Test 1: one full 2048-word region
        clear_logs();
        tb_base[0] = 12'h000; tb_len[0] = 13'd2048;
        tb_base[1] = 12'h7A0; tb_len[1] = 13'd300;
        set_tables(4'b0001);
        a = cyc + 1;
        pulse(a);
        model_add(a, d1);
        goto(d1 + 4);
        compare_logs("t1");
        chk("t1 done offset", first_done() - a, 2051);
        bad = 0;
        for (int i = 0; i < 2048; i++) if (dst_mem[i] !== {52'h0, 12'(i)}) bad++;
        chk("t1 dst copied", bad, 0);
        bad = 0;
        for (int i = 2048; i < 4096; i++) if (dst_mem[i] !== 64'hDEAD_BEEF_DEAD_BEEF) bad++;
        chk("t1 dst untouched", bad, 0);

        // Test 2: regions 0 and 2 back to back, region 1 skipped
        clear_logs();
        tb_base[0] = 12'h000; tb_len[0] = 13'd16;
        tb_base[1] = 12'h400; tb_len[1] = 13'd32;
        tb_base[2] = 12'h800; tb_len[2] = 13'd8;
        set_tables(4'b0101);
        a = cyc + 1;
        pulse(a);
        model_add(a, d1);
        goto(d1 + 4);
        compare_logs("t2");
        chk("t2 done offset", first_done() - a, 27);

        // Test 3: address wrap at the top of VRAM
        clear_logs();
        tb_base[3] = 12'hFFE; tb_len[3] = 13'd4;
        set_tables(4'b1000);
        a = cyc + 1;
        pulse(a);
        model_add(a, d1);
        goto(d1 + 4);
        compare_logs("t3");
        chk("t3 done offset", first_done() - a, 7);

        // Test 4: empty requests
        clear_logs();
        set_tables(4'b0000);
        a = cyc + 1;
        pulse(a);
        model_add(a, d1);
        goto(d1 + 4);
        compare_logs("t4 nomask");
        chk("t4 nomask done offset", first_done() - a, 1);
        clear_logs();
        tb_len[1] = 13'd0; tb_len[2] = 13'd0;
        set_tables(4'b0110);
        a = cyc + 1;
        pulse(a);
        model_add(a, d1);
        goto(d1 + 4);
        compare_logs("t4 zerolen");

        // Test 5: pending request and overrun
        clear_logs();
        tb_base[0] = 12'h000; tb_len[0] = 13'd2048;
        set_tables(4'b0001);
        a = cyc + 1;
        pulse(a);
        model_add(a, d1);
        model_add(d1, d2);
        exp_ovr.push_back(a + 11);
        pulse(a + 5);
        pulse(a + 10);
        goto(d2 + 4);
        compare_logs("t5");
        chk("t5 first done", first_done() - a, 2051);
        chk("t5 second done", (obs_done.size() > 1 ? obs_done[1] : -1) - a, 4102);

        // Test 6: reset mid-copy with a pending request
        clear_logs();
        a = cyc + 1;
        pulse(a);
        pulse(a + 5);
        goto(a + 100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6 rd_en after rst", ifc.src_rd_en, 0);
        chk("t6 wr_en after rst", ifc.dst_wr_en, 0);
        chk("t6 busy after rst", ifc.busy, 0);
        chk("t6 done after rst", ifc.done, 0);
        goto(a + 120);
        for (int k = 0; k < 100; k++) exp_rd.push_back(ev_t'{a + 1 + k, 12'(k), 64'h0});
        for (int k = 0; k < 98; k++) exp_wr.push_back(ev_t'{a + 3 + k, 12'(k), {52'h0, 12'(k)}});
        exp_busy_n = 100; exp_busy_first = a + 1; exp_busy_last = a + 100;
        compare_logs("t6 aborted");
        clear_logs();
        a = cyc + 1;
        pulse(a);
        model_add(a, d1);
        goto(d1 + 4);
        compare_logs("t6 fresh");

        // Randomized tables; inputs scrambled after latch, some with pending
        for (int it = 0; it < 10; it++) begin
            clear_logs();
            for (int i = 0; i < NR; i++) begin
                tb_base[i] = 12'($urandom);
                tb_len[i]  = ($urandom_range(0, 3) == 0) ? 13'd0 : 13'($urandom_range(1, 40));
            end
            set_tables(4'($urandom));
            a = cyc + 1;
            pulse(a);
            model_add(a, d1);
            d2 = d1;
            for (int i = 0; i < NR; i++) begin
                tb_base[i] = 12'($urandom);
                tb_len[i]  = 13'($urandom_range(0, 20));
            end
            set_tables(4'($urandom));
            if (it[0] && last_s > 0) begin
                pulse(a + 2);
                model_add(d1, d2);
            end
            goto(d2 + 4);
            compare_logs($sformatf("rand%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
